ps2_kbd_event_rx: RTL
=====================

// Module: ps2_kbd_event_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver, successor of the single-byte FIFO receiver.
//  - Filters and synchronises the PS/2 lines, then deframes 11-bit frames.
//  - Folds E0/F0 prefixes into one key event {ext, brk, code}.
//  - Buffers events in a DEPTH-entry FIFO with an explicit pop handshake.
//  - Reports parity errors, framing errors, timeouts and overflow separately.
//  - Sits between the board PS/2 pins and the keyboard-consuming logic (display, CPU MMIO).
// PARAMETERS
//  FIFO_DEPTH   8       event FIFO entries; power of 2, >=2
//  SYNC_STAGES  3       flops on ps2_clk/ps2_data before filtering; >=2
//  FILTER_LEN   4       consecutive equal samples before filtered ps2_clk changes
//  TIMEOUT_CYC  100000  clk cycles without a sample strobe mid-frame before abort
//  CNT_W        8       width of release_cnt
// PORTS
//  clk          in   1        system clock
//  clrn         in   1        asynchronous active-low reset
//  ps2_clk      in   1        raw PS/2 clock pin
//  ps2_data     in   1        raw PS/2 data pin
//  rd_en        in   1        pop head event; honoured only when ready=1
//  data         out  8        head event scan code (prefixes stripped)
//  is_ext       out  1        head event was preceded by E0
//  is_break     out  1        head event was preceded by F0 (key release)
//  ready        out  1        FIFO non-empty; data/is_ext/is_break valid
//  level        out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  overflow     out  1        sticky: an event was dropped because the FIFO was full
//  parity_err   out  1        1-cycle pulse: frame discarded, even parity over data+parity bits
//  frame_err    out  1        1-cycle pulse: bad stop bit or timeout
//  release_cnt  out  CNT_W    count of break events pushed; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: clk/clrn asynchronous, all outputs 0, FSM in IDLE, FIFO empty, prefix flags clear.
//  - Input conditioning:
//    - Both pins pass SYNC_STAGES flops.
//    - Filtered ps2_clk toggles only after FILTER_LEN equal consecutive samples.
//    - strobe = 1-cycle pulse on each filtered falling edge; ps2_data sampled at the same cycle.
//  - Frame FSM:
//    - IDLE: strobe & data=0 -> RECV, bit_idx=0. Strobe with data=1 is ignored and the FSM stays in IDLE.
//    - RECV: each strobe shifts one bit, LSB first (8 data + parity). After the 9th -> STOP.
//    - STOP, on strobe:
//      - stop=1 and odd parity -> byte accepted, go to IDLE.
//      - stop=0 -> frame_err, go to IDLE.
//      - stop=1, bad parity -> parity_err, go to IDLE.
//    - RECV/STOP timeout: idle counter resets on every strobe. At TIMEOUT_CYC -> IDLE, frame_err.
//  - Prefix decode on an accepted byte:
//    - E0: set ext_f; no push.
//    - F0: set brk_f; no push.
//    - Any other byte (E1 included): push {ext_f, brk_f, byte}, then clear both flags.
//    - Any parity_err/frame_err also clears both flags.
//  - Latency: push in the cycle after the stop-bit strobe; ready=1 the cycle after the push.
//  - FIFO behaviour:
//    - First-word-fall-through: head event is visible while ready=1.
//    - rd_en&ready pops; the next entry is visible the following cycle.
//    - rd_en while empty: ignored, no pointer movement.
//    - Push while full and no pop: event dropped, overflow<=1 (sticky until reset), pointers unchanged.
//    - Push and pop in the same cycle, including when full: both performed; level unchanged; no overflow.
//    - Pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty use the MSB compare; wrap is natural.
//  - release_cnt increments in the same cycle as the push of any event with brk=1.
//  - Reset mid-frame discards the partial frame, the FIFO contents and the prefix state.
// STRUCTURE
//  - Shared package ps2_pkg holds:
//    - localparams PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0;
//    - FSM encodings IDLE/RECV/STOP;
//    - event width EV_W=10 and the field offsets of {ext,brk,code}.
//  - One sub-module, ps2_event_fifo (params DEPTH, W). It owns the pointers, level, full/empty
//    and the overflow detect.
//  - The top holds sync/filter, the frame FSM, the timeout counter, the prefix decoder and release_cnt.
// TESTING
//  1. Frame 0x1C (A make), rd_en=0 -> ready=1, data=1C, is_ext=0, is_break=0, level=1.
//  2. Bytes F0,1C -> one event data=1C, is_break=1; release_cnt 0->1; level=1 (prefix not queued).
//  3. Bytes E0,F0,75 -> data=75, is_ext=1, is_break=1. Then E0,75 -> is_ext=1, is_break=0.
//  4. FIFO_DEPTH+1 make codes, no pops -> level=FIFO_DEPTH, overflow=1, head = first code.
//     Then pop all; codes come out in order and ready=0 after the last pop.
//  5. Frame with a flipped parity bit -> parity_err pulse, no push.
//     Stop bit=0 -> frame_err pulse, no push. A preceding F0 is forgotten in both cases.
//  6. Stop ps2_clk after 4 bits -> frame_err exactly TIMEOUT_CYC cycles after the last strobe.
//     The next full frame is received correctly.
//  7. Glitch: ps2_clk low for FILTER_LEN-1 cycles -> no strobe, no bit consumed.
//  8. Pop and push in the same cycle with the FIFO full -> level stays FIFO_DEPTH, overflow=0.
//  9. clrn asserted mid-frame with 3 events queued -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard event receiver.
//  - Prefix byte values folded into key events (E0 extended, F0 break).
//  - Frame FSM state encoding.
//  - Event word layout {ext, brk, code} and a packing helper.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        STOP = 2'd2
    } ps2_state_e;

    localparam int EV_W        = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_CODE_W   = 8;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    function automatic logic [EV_W-1:0] ev_pack(input logic ext, input logic brk,
                                                input logic [EV_CODE_W-1:0] code);
        logic [EV_W-1:0] ev;
        ev = '0;
        ev[EV_EXT_BIT] = ext;
        ev[EV_BRK_BIT] = brk;
        ev[EV_CODE_LSB +: EV_CODE_W] = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO for the PS/2 receiver.
// Ports:
//  clk, clrn     system clock, asynchronous active-low reset
//  push_i        write wdata_i this cycle
//  wdata_i       event word
//  pop_i         consume head entry (ignored while empty)
//  rdata_o       head entry, valid while empty_o=0
//  empty_o       no entries held
//  level_o       occupancy, 0..DEPTH
//  push_ok_o     push_i was accepted this cycle
//  overflow_o    sticky: a push was dropped because the FIFO was full
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    push_i,
    input  logic [W-1:0]            wdata_i,
    input  logic                    pop_i,
    output logic [W-1:0]            rdata_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    push_ok_o,
    output logic                    overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         ovf_q, ovf_d;
    logic         full;
    logic         pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok    = pop_i & ~empty_o;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok_o = push_i & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok_o) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)    rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_i && !push_ok_o) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver producing prefix-folded key events.
// Ports:
//  clk, clrn            system clock, asynchronous active-low reset
//  ps2_clk, ps2_data    raw PS/2 pins
//  rd_en                pop head event (honoured only while ready=1)
//  data/is_ext/is_break head event {code, E0 seen, F0 seen}; 0 while empty
//  ready                FIFO non-empty
//  level                FIFO occupancy
//  overflow             sticky, an event was dropped on a full FIFO
//  parity_err           1-cycle pulse, frame discarded on even parity
//  frame_err            1-cycle pulse, bad stop bit or mid-frame timeout
//  release_cnt          break events accepted into the FIFO, wrapping
//
// Frame FSM
//  state | meaning
//  IDLE  | waiting for a strobe with data=0 (start bit)
//  RECV  | shifting 8 data bits + parity, LSB first
//  STOP  | next strobe carries the stop bit; check stop and parity
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         rd_en,
    output logic [7:0]                   data,
    output logic                         is_ext,
    output logic                         is_break,
    output logic                         ready,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         overflow,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic [CNT_W-1:0]             release_cnt
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // Loaded on the strobe cycle; terminal count lands frame_err exactly
    // TIMEOUT_CYC cycles after that strobe (one cycle of register latency).
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Input synchronisers; idle PS/2 lines are high.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic clk_s, data_s;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Glitch filter: FILTER_LEN consecutive samples differing from the
    // filtered level are needed before it follows.
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    always_comb begin
        clk_f_d    = clk_f_q;
        filt_cnt_d = FILT_LOAD;
        strobe     = 1'b0;
        if (clk_s != clk_f_q) begin
            if (filt_cnt_q == '0) begin
                clk_f_d = clk_s;
                strobe  = clk_f_q;
            end else begin
                filt_cnt_d = filt_cnt_q - FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_f_q    <= 1'b1;
            filt_cnt_q <= FILT_LOAD;
        end else begin
            clk_f_q    <= clk_f_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Frame FSM with timeout down-counter.
    ps2_state_e    state_q, state_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = TMO_LOAD;
                if (strobe && !data_s) begin
                    state_d   = RECV;
                    bit_idx_d = '0;
                end
            end
            RECV: begin
                if (strobe) begin
                    shift_d   = {data_s, shift_q[8:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    tmo_d     = TMO_LOAD;
                    if (bit_idx_q == 4'd8) state_d = STOP;
                end else if (tmo_q == '0) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            STOP: begin
                if (strobe) begin
                    state_d = IDLE;
                    if (!data_s) begin
                        ferr_d = 1'b1;
                    end else if (^shift_q) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q[7:0];
                    end else begin
                        perr_d = 1'b1;
                    end
                end else if (tmo_q == '0) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= TMO_LOAD;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Prefix decoder: runs in the cycle after the stop-bit strobe.
    logic                 ext_q, ext_d;
    logic                 brk_q, brk_d;
    logic                 push;
    logic                 push_ok;
    logic [CNT_W-1:0]     rel_q, rel_d;
    logic [EV_W-1:0]      head_ev;
    logic                 fifo_empty;

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (perr_q || ferr_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_comb begin
        rel_d = rel_q;
        if (push_ok && brk_q) rel_d = rel_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            rel_q <= '0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            rel_q <= rel_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk        (clk),
        .clrn       (clrn),
        .push_i     (push),
        .wdata_i    (ev_pack(ext_q, brk_q, byte_q)),
        .pop_i      (rd_en),
        .rdata_o    (head_ev),
        .empty_o    (fifo_empty),
        .level_o    (level),
        .push_ok_o  (push_ok),
        .overflow_o (overflow)
    );

    // Head fields are forced to 0 while empty so stale memory never shows.
    assign ready       = ~fifo_empty;
    assign data        = ready ? head_ev[EV_CODE_LSB +: EV_CODE_W] : 8'h00;
    assign is_ext      = ready & head_ev[EV_EXT_BIT];
    assign is_break    = ready & head_ev[EV_BRK_BIT];
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign release_cnt = rel_q;

endmodule
